// File: rtl/count_capture_fifo.sv
// ---------------------------------------------------------------------------
// count_capture_fifo
//
// Purpose
//   Timestamp capture stage that sits directly after the free-running counter.
//   Counter wraps (overflow pulses) are tracked in an epoch register. Each
//   rising edge of the asynchronous cap_in input is synchronised, and the
//   stamp {epoch, count} is pushed into a DEPTH-entry FIFO. A consumer drains
//   the FIFO through a valid/ready handshake.
//
// Parameters
//   WIDTH    width of the count input (matches the upstream counter)
//   EPOCH_W  width of the overflow epoch counter
//   DEPTH    FIFO entries; power of two, >= 2
//
// Ports
//   clk        in   1               clock
//   rst_n      in   1               asynchronous active-low reset
//   count      in   WIDTH           counter value (registered upstream)
//   overflow   in   1               one-cycle wrap pulse (cycle where count==0)
//   cap_in     in   1               asynchronous capture event, rising edge
//   clr        in   1               synchronous clear, highest priority
//   cap_valid  out  1               FIFO head valid (== !empty)
//   cap_ready  in   1               consumer accepts the head entry
//   cap_data   out  EPOCH_W+WIDTH   head entry {epoch, count}; 0 when empty
//   full       out  1               FIFO holds DEPTH entries
//   empty      out  1               FIFO holds no entries
//   overrun    out  1               sticky flag: an event was dropped
//   drop_cnt   out  8               saturating count of dropped events
//
// Build option
//   CAPTURE_DROP_CNT_EN  when defined, drop_cnt counts dropped events and
//                        saturates at 8'hFF; when undefined, drop_cnt is
//                        tied to 8'h00 and no counter is built.
// ---------------------------------------------------------------------------
module count_capture_fifo #(
    parameter int WIDTH   = 8,
    parameter int EPOCH_W = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         count,
    input  logic                     overflow,
    input  logic                     cap_in,
    input  logic                     clr,
    output logic                     cap_valid,
    input  logic                     cap_ready,
    output logic [EPOCH_W+WIDTH-1:0] cap_data,
    output logic                     full,
    output logic                     empty,
    output logic                     overrun,
    output logic [7:0]               drop_cnt
);

    localparam int DW = EPOCH_W + WIDTH;
    localparam int AW = $clog2(DEPTH);

    // -----------------------------------------------------------------------
    // Capture input synchroniser and rising-edge detector.
    // r_s1/r_s2 form the two-flop synchroniser; r_s3 remembers the previous
    // synchronised level so each rising edge produces a single-cycle event.
    // These flops are deliberately not touched by clr.
    // -----------------------------------------------------------------------
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic w_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= cap_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_evt = r_s2 & ~r_s3;

    // -----------------------------------------------------------------------
    // Epoch tracking. When the event coincides with the wrap cycle the stamp
    // must carry the incremented epoch so that count==0 is paired with the
    // epoch it belongs to, not the one that just ended.
    // -----------------------------------------------------------------------
    logic [EPOCH_W-1:0] r_epoch;
    logic [EPOCH_W-1:0] w_epoch_inc;
    logic [EPOCH_W-1:0] w_stamp_epoch;
    logic [DW-1:0]      w_stamp;

    assign w_epoch_inc   = r_epoch + EPOCH_W'(1);
    assign w_stamp_epoch = overflow ? w_epoch_inc : r_epoch;
    assign w_stamp       = {w_stamp_epoch, count};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epoch <= '0;
        end else if (clr) begin
            r_epoch <= '0;
        end else if (overflow) begin
            r_epoch <= w_epoch_inc;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO control. The occupancy counter is one bit wider than the pointers
    // so full and empty are distinguishable; pointers wrap naturally because
    // DEPTH is a power of two.
    // -----------------------------------------------------------------------
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_occ;
    logic          r_overrun;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == (AW+1)'(DEPTH));

    // A full FIFO that is popped in the same cycle still has room for the
    // incoming stamp, so the pop term is folded into the push qualifier.
    assign w_pop  = ~w_empty & cap_ready;
    assign w_push = w_evt & (~w_full | w_pop);
    assign w_drop = w_evt & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_overrun <= 1'b0;
        end else if (clr) begin
            // clr discards any concurrent event, pop or overflow.
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - (AW+1)'(1);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage. No reset on the array: an entry is only ever observed
    // after it has been written, and the output is forced to zero while the
    // FIFO is empty. The head is read combinationally from the read pointer
    // so a push into an empty FIFO appears one cycle later (no bypass).
    // -----------------------------------------------------------------------
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_mem[r_wr_ptr] <= w_stamp;
        end
    end

    assign cap_valid = ~w_empty;
    assign cap_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full      = w_full;
    assign empty     = w_empty;
    assign overrun   = r_overrun;

    // -----------------------------------------------------------------------
    // Optional dropped-event counter.
    // -----------------------------------------------------------------------
`ifdef CAPTURE_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'h00;
        end else if (clr) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_count_capture_fifo.sv
`timescale 1ns/1ps
module tb_count_capture_fifo;

    localparam int WIDTH   = 8;
    localparam int EPOCH_W = 8;
    localparam int DEPTH   = 4;
    localparam int DW      = EPOCH_W + WIDTH;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic [WIDTH-1:0]  count     = '0;
    logic              overflow  = 1'b0;
    logic              cap_in    = 1'b0;
    logic              clr       = 1'b0;
    logic              cap_ready = 1'b0;
    logic              cap_valid;
    logic [DW-1:0]     cap_data;
    logic              full;
    logic              empty;
    logic              overrun;
    logic [7:0]        drop_cnt;

    count_capture_fifo #(
        .WIDTH   (WIDTH),
        .EPOCH_W (EPOCH_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (count),
        .overflow  (overflow),
        .cap_in    (cap_in),
        .clr       (clr),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_data  (cap_data),
        .full      (full),
        .empty     (empty),
        .overrun   (overrun),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard and reference state.
    logic [DW-1:0]      exp_q [$];
    logic [EPOCH_W-1:0] m_epoch = '0;
    int                 m_drop  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] exp_drop();
`ifdef CAPTURE_DROP_CNT_EN
        return (m_drop > 255) ? 8'hFF : 8'(m_drop);
`else
        return 8'h00;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag);
        if (exp_q.size() == 0)
            chk({tag, "_sb_empty"}, {31'd0, cap_valid}, 32'd0);
        else
            chk(tag, 32'(cap_data), 32'(exp_q[0]));
    endtask

    task automatic pop_one(input string tag);
        chk({tag, "_valid"}, {31'd0, cap_valid}, 32'd1);
        check_head(tag);
        cap_ready = 1'b1;
        step();
        cap_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        $display("pop  %s remaining=%0d", tag, exp_q.size());
    endtask

    task automatic ovf_pulse();
        overflow = 1'b1;
        step();
        overflow = 1'b0;
        m_epoch = m_epoch + 8'd1;
        $display("ovf  epoch=%0h", m_epoch);
    endtask

    // One capture event: cap_in is sampled high at edge N, the event is live
    // in the cycle after edge N+1 and the stamp is written at edge N+2.
    // ovf / rdy / clr_e are applied during that event cycle.
    task automatic do_event(input logic [7:0] cnt, input logic ovf, input logic rdy, input logic clr_e);
        logic [EPOCH_W-1:0] e;
        logic popped;
        logic was_full;
        count  = cnt;
        cap_in = 1'b1;
        step();
        cap_in = 1'b0;
        step();
        overflow = ovf;
        clr      = clr_e;
        if (rdy) begin
            check_head("head_before_pop");
            cap_ready = 1'b1;
        end
        step();
        if (clr_e) begin
            exp_q.delete();
            m_epoch = '0;
            m_drop  = 0;
        end else begin
            e        = ovf ? m_epoch + 8'd1 : m_epoch;
            popped   = rdy && (exp_q.size() > 0);
            was_full = (exp_q.size() == DEPTH);
            if (popped) void'(exp_q.pop_front());
            if (!was_full || popped) exp_q.push_back({e, cnt});
            else m_drop++;
            if (ovf) m_epoch = m_epoch + 8'd1;
        end
        overflow  = 1'b0;
        clr       = 1'b0;
        cap_ready = 1'b0;
        $display("evt  count=%0h ovf=%0b rdy=%0b clr=%0b queued=%0d drops=%0d",
                 cnt, ovf, rdy, clr_e, exp_q.size(), m_drop);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_valid",    {31'd0, cap_valid}, 32'd0);
        chk("rst_empty",    {31'd0, empty},     32'd1);
        chk("rst_full",     {31'd0, full},      32'd0);
        chk("rst_overrun",  {31'd0, overrun},   32'd0);
        chk("rst_drop_cnt", {24'd0, drop_cnt},  32'd0);
        chk("rst_data",     {16'd0, cap_data},  32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- 1: latency and first stamp ----------------
        count  = 8'h37;
        cap_in = 1'b1;
        step();                                   // edge N samples cap_in
        cap_in = 1'b0;
        chk("t1_valid_N",  {31'd0, cap_valid}, 32'd0);
        step();                                   // edge N+1
        chk("t1_valid_N1", {31'd0, cap_valid}, 32'd0);
        exp_q.push_back(16'h0037);
        step();                                   // edge N+2 writes the entry
        chk("t1_valid_N2", {31'd0, cap_valid}, 32'd1);
        chk("t1_data",     {16'd0, cap_data},  32'h0037);
        $display("evt  count=37 first capture");
        pop_one("t1_pop");
        chk("t1_empty", {31'd0, empty}, 32'd1);

        // ---------------- 2: epoch tracking ----------------
        ovf_pulse();
        ovf_pulse();
        ovf_pulse();
        do_event(8'h05, 1'b0, 1'b0, 1'b0);
        chk("t2_data_0305", {16'd0, cap_data}, 32'h0305);
        pop_one("t2_pop_a");
        do_event(8'h00, 1'b1, 1'b0, 1'b0);
        chk("t2_data_0400", {16'd0, cap_data}, 32'h0400);
        pop_one("t2_pop_b");

        // ---------------- 3: fill, overrun, ordered drain ----------------
        for (int i = 0; i < 5; i++) begin
            do_event(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
            if (i == 3) begin
                chk("t3_full_4th",    {31'd0, full},    32'd1);
                chk("t3_overrun_4th", {31'd0, overrun}, 32'd0);
            end
        end
        chk("t3_overrun_5th", {31'd0, overrun},  32'd1);
        chk("t3_full_5th",    {31'd0, full},     32'd1);
        chk("t3_drop_cnt",    {24'd0, drop_cnt}, {24'd0, exp_drop()});
        for (int i = 0; i < DEPTH; i++) pop_one("t3_drain");
        chk("t3_empty", {31'd0, empty}, 32'd1);

        // ---------------- 4: full FIFO, pop and push together ----------------
        for (int i = 0; i < DEPTH; i++) do_event(8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        chk("t4_full_before", {31'd0, full}, 32'd1);
        do_event(8'h24, 1'b0, 1'b1, 1'b0);
        chk("t4_full_after", {31'd0, full},     32'd1);
        chk("t4_drop_cnt",   {24'd0, drop_cnt}, {24'd0, exp_drop()});
        chk("t4_head_adv",   {16'd0, cap_data}, 32'h0421);
        for (int i = 0; i < DEPTH; i++) pop_one("t4_drain");
        chk("t4_empty", {31'd0, empty}, 32'd1);

        // ---------------- 5: drop saturation, then clr ----------------
        for (int i = 0; i < DEPTH; i++) do_event(8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) do_event(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        chk("t5_drop_sat", {24'd0, drop_cnt}, {24'd0, exp_drop()});
        chk("t5_overrun",  {31'd0, overrun},  32'd1);
        check_head("t5_head_kept");
        do_event(8'h55, 1'b1, 1'b0, 1'b1);        // evt + overflow + clr together
        chk("t5_clr_empty",   {31'd0, empty},     32'd1);
        chk("t5_clr_valid",   {31'd0, cap_valid}, 32'd0);
        chk("t5_clr_overrun", {31'd0, overrun},   32'd0);
        chk("t5_clr_drop",    {24'd0, drop_cnt},  32'd0);
        do_event(8'h21, 1'b0, 1'b0, 1'b0);
        chk("t5_epoch_zero", {16'd0, cap_data}, 32'h0021);
        pop_one("t5_pop");

        // ---------------- 6: asynchronous reset mid-operation ----------------
        ovf_pulse();
        do_event(8'h61, 1'b0, 1'b0, 1'b0);
        do_event(8'h62, 1'b0, 1'b0, 1'b0);
        chk("t6_valid_pre", {31'd0, cap_valid}, 32'd1);
        check_head("t6_head_pre");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, cap_valid}, 32'd0);
        chk("t6_async_empty", {31'd0, empty},     32'd1);
        chk("t6_async_data",  {16'd0, cap_data},  32'd0);
        exp_q.delete();
        m_epoch = '0;
        m_drop  = 0;
        $display("rst  asserted mid-operation");
        step();
        rst_n = 1'b1;
        step();
        do_event(8'h70, 1'b0, 1'b0, 1'b0);
        chk("t6_epoch_rst", {16'd0, cap_data}, 32'h0070);
        pop_one("t6_pop");
        chk("t6_final_empty", {31'd0, empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
